// File: rtl/count_game_ctrl.sv
// count_game_ctrl: key front end and game sequencer for the counting game.
// Each key is synchronised, debounced and turned into a one-cycle press
// pulse. A start press begins a countdown from START_VAL to 0, one step every
// TICKS_PER_SEC cycles. Hit presses during the countdown are counted and
// saturate at 255. 'done' flags the end of the game.
// Optional build macro: COUNT_GAME_PAUSE_EN adds a PAUSE state. With it, a
// start press during RUN freezes the game, and the next start press resumes it.
`timescale 1ns/1ps

module count_game_ctrl #(
  parameter int START_VAL     = 6,
  parameter int TICKS_PER_SEC = 1000,
  parameter int DEB_CYCLES    = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_start,
  input  logic       key_hit,
  output logic [2:0] num,
  output logic [7:0] hit_cnt,
  output logic       done
);

  localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
  localparam logic [2:0]        START_NUM = 3'(START_VAL);

`ifdef COUNT_GAME_PAUSE_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2,
    S_PAUSE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2
  } state_t;
`endif

  // Bit 0 is the start key and bit 1 is the hit key.
  logic [1:0] w_raw_keys;
  logic [1:0] w_press;
  logic       w_start;
  logic       w_hit;

  assign w_raw_keys = {key_hit, key_start};
  assign w_start    = w_press[0];
  assign w_hit      = w_press[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_key
      logic             r_sync0;
      logic             r_sync1;
      logic             r_stable;
      logic             r_press;
      logic [DEB_W-1:0] r_deb_cnt;

      // Synchronise the key, and accept a new level once it has differed from
      // the stable level for DEB_CYCLES cycles in a row. Only a 0->1 change
      // produces a press pulse.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sync0   <= 1'b0;
          r_sync1   <= 1'b0;
          r_stable  <= 1'b0;
          r_press   <= 1'b0;
          r_deb_cnt <= '0;
        end else begin
          r_sync0 <= w_raw_keys[gi];
          r_sync1 <= r_sync0;
          r_press <= 1'b0;
          if (r_sync1 == r_stable) begin
            r_deb_cnt <= '0;
          end else if (r_deb_cnt == DEB_LAST) begin
            r_stable  <= r_sync1;
            r_deb_cnt <= '0;
            r_press   <= r_sync1;
          end else begin
            r_deb_cnt <= r_deb_cnt + DEB_W'(1);
          end
        end
      end

      assign w_press[gi] = r_press;
    end
  endgenerate

  state_t              r_state;
  state_t              w_state_next;
  logic [TICK_W-1:0]   r_tick;
  logic [TICK_W-1:0]   w_tick_next;
  logic [2:0]          r_num;
  logic [2:0]          w_num_next;
  logic [7:0]          r_hit_cnt;
  logic [7:0]          w_hit_cnt_next;
  logic                r_done;
  logic                w_done_next;

  // Game state register. All outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_tick    <= '0;
      r_num     <= START_NUM;
      r_hit_cnt <= 8'd0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_tick    <= w_tick_next;
      r_num     <= w_num_next;
      r_hit_cnt <= w_hit_cnt_next;
      r_done    <= w_done_next;
    end
  end

  // Next-state logic. A start press always takes priority over a hit press
  // in the same cycle.
  always_comb begin
    w_state_next   = r_state;
    w_tick_next    = r_tick;
    w_num_next     = r_num;
    w_hit_cnt_next = r_hit_cnt;
    w_done_next    = r_done;

    case (r_state)
      S_IDLE: begin
        w_num_next  = START_NUM;
        w_done_next = 1'b0;
        if (w_start) begin
          w_state_next   = S_RUN;
          w_tick_next    = '0;
          w_hit_cnt_next = 8'd0;
        end
      end

      S_RUN: begin
        if (w_start) begin
`ifdef COUNT_GAME_PAUSE_EN
          w_state_next = S_PAUSE;
`else
          w_tick_next    = '0;
          w_num_next     = START_NUM;
          w_hit_cnt_next = 8'd0;
`endif
        end else begin
          if (w_hit && (r_hit_cnt != 8'hFF)) begin
            w_hit_cnt_next = r_hit_cnt + 8'd1;
          end
          if (r_tick == TICK_LAST) begin
            w_tick_next = '0;
            if (r_num == 3'd1) begin
              // The final wrap ends the game on this same edge.
              w_num_next   = 3'd0;
              w_state_next = S_DONE;
              w_done_next  = 1'b1;
            end else begin
              w_num_next = r_num - 3'd1;
            end
          end else begin
            w_tick_next = r_tick + TICK_W'(1);
          end
        end
      end

      S_DONE: begin
        w_num_next  = 3'd0;
        w_done_next = 1'b1;
        if (w_start) begin
          w_state_next   = S_RUN;
          w_tick_next    = '0;
          w_num_next     = START_NUM;
          w_hit_cnt_next = 8'd0;
          w_done_next    = 1'b0;
        end
      end

`ifdef COUNT_GAME_PAUSE_EN
      S_PAUSE: begin
        // Tick, num and hit_cnt stay frozen. Hits are ignored while paused.
        if (w_start) begin
          w_state_next = S_RUN;
        end
      end
`endif

      default: begin
        w_state_next = S_IDLE;
        w_tick_next  = '0;
        w_num_next   = START_NUM;
        w_done_next  = 1'b0;
      end
    endcase
  end

  assign num     = r_num;
  assign hit_cnt = r_hit_cnt;
  assign done    = r_done;

endmodule
